// File: rtl/rob_cmplt_arb.sv
// rtl/rob_cmplt_arb.sv - round-robin completion arbiter feeding the ROB completion port
module rob_cmplt_arb #(
    parameter  int N_REQ    = 6,
    parameter  int GRANTS   = 3,
    parameter  int ELEMENTS = 15,
    localparam int TAG_W    = $clog2(ELEMENTS + 1) + 1,
    localparam int CNT_W    = $clog2(GRANTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    output logic [N_REQ-1:0]          req_ready,
    output logic [GRANTS*TAG_W-1:0]   completed,
    output logic [GRANTS-1:0]         cmplt_valid,
    output logic [CNT_W-1:0]          grant_ct
);

    localparam int PTR_W = $clog2(N_REQ);
    // One extra bit so rr_ptr + i never overflows before the wrap subtract.
    localparam int IDX_W = PTR_W + 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] idx;
    logic [IDX_W-1:0] idx_w;
    logic [CNT_W-1:0] cnt;
    logic             any_grant;

    logic [TAG_W-1:0] tag_arr  [N_REQ];
    logic [TAG_W-1:0] slot_tag [GRANTS];
    logic [TAG_W-1:0] slot_q   [GRANTS];
    logic [GRANTS-1:0] slot_vld;
    logic [GRANTS-1:0] vld_q;
    logic [CNT_W-1:0]  cnt_q;

    genvar gr;
    generate
        for (gr = 0; gr < N_REQ; gr++) begin : g_unpack
            assign tag_arr[gr] = req_tag[gr*TAG_W +: TAG_W];
        end
        for (gr = 0; gr < GRANTS; gr++) begin : g_pack
            assign completed[gr*TAG_W +: TAG_W] = slot_q[gr];
        end
    endgenerate

    // Walk units in rotating priority order, granting the first GRANTS valid ones
    // and packing their tags into consecutive slots from slot 0.
    always_comb begin
        req_ready = '0;
        slot_vld  = '0;
        cnt       = '0;
        last_idx  = rr_ptr;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < GRANTS; k++) begin
            slot_tag[k] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            idx_w = {1'b0, rr_ptr} + IDX_W'(i);
            if (idx_w >= IDX_W'(N_REQ)) begin
                idx_w = idx_w - IDX_W'(N_REQ);
            end
            idx = idx_w[PTR_W-1:0];
            if (!flush && req_valid[idx] && (cnt < CNT_W'(GRANTS))) begin
                req_ready[idx] = 1'b1;
                slot_tag[cnt]  = tag_arr[idx];
                slot_vld[cnt]  = 1'b1;
                cnt            = cnt + CNT_W'(1);
                last_idx       = idx;
            end
        end
        any_grant = (cnt != '0);
        nxt_ptr   = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end

    // Register the packed slots for the ROB bus and advance the pointer past the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < GRANTS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            vld_q <= slot_vld;
            cnt_q <= cnt;
            for (int k = 0; k < GRANTS; k++) begin
                slot_q[k] <= slot_tag[k];
            end
            if (any_grant) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

    assign cmplt_valid = vld_q;
    assign grant_ct    = cnt_q;

endmodule

// File: tb/tb_rob_cmplt_arb.sv
// tb/tb_rob_cmplt_arb.sv - directed and held-random checks of rob_cmplt_arb
module tb_rob_cmplt_arb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [5:0]  req_valid;
    logic [29:0] req_tag;
    logic [5:0]  req_ready;
    logic [14:0] completed;
    logic [2:0]  cmplt_valid;
    logic [1:0]  grant_ct;

    int checks = 0;
    int errors = 0;

    rob_cmplt_arb #(.N_REQ(6), .GRANTS(3), .ELEMENTS(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .completed   (completed),
        .cmplt_valid (cmplt_valid),
        .grant_ct    (grant_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_tag(input int r, input logic [4:0] t);
        req_tag[r*5 +: 5] = t;
    endtask

    function automatic logic [14:0] slots(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    logic [5:0]  pend;
    logic [4:0]  ptag [6];
    int          wait_c [6];
    logic [14:0] exp_c;
    logic [2:0]  exp_v;
    logic [1:0]  exp_n;
    logic [5:0]  exp_rdy;
    int          mptr;
    int          g;
    int          last;
    int          r;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        repeat (2) @(negedge clk);
        chk("reset_vld", 32'(cmplt_valid), 0);
        chk("reset_cmplt", 32'(completed), 0);
        rst_n = 1'b1;

        // Idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_vld", 32'(cmplt_valid), 0);
            chk("idle_ptr", 32'(dut.rr_ptr), 0);
        end

        // Partial grant
        req_valid = 6'b000011;
        set_tag(0, 5'd5);
        set_tag(1, 5'd9);
        #1;
        chk("part_rdy", 32'(req_ready), 32'h03);
        @(negedge clk);
        chk("part_cmplt", 32'(completed), 32'(slots(5'd5, 5'd9, 5'd0)));
        chk("part_vld", 32'(cmplt_valid), 32'h3);
        chk("part_ct", 32'(grant_ct), 2);
        chk("part_ptr", 32'(dut.rr_ptr), 2);
        req_valid = '0;

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cmplt", 32'(completed), 0);
        chk("arst_vld", 32'(cmplt_valid), 0);
        chk("arst_ct", 32'(grant_ct), 0);
        chk("arst_ptr", 32'(dut.rr_ptr), 0);
        req_valid = 6'b110000;
        #1;
        chk("arst_rdy", 32'(req_ready), 32'h30);
        req_valid = '0;
        #1 rst_n = 1'b1;

        // Saturation and rotation
        @(negedge clk);
        for (int i = 0; i < 6; i++) set_tag(i, 5'(i + 1));
        req_valid = 6'b111111;
        #1;
        chk("sat_rdy0", 32'(req_ready), 32'h07);
        @(negedge clk);
        chk("sat_cmplt0", 32'(completed), 32'(slots(5'd1, 5'd2, 5'd3)));
        chk("sat_vld0", 32'(cmplt_valid), 32'h7);
        chk("sat_ct0", 32'(grant_ct), 3);
        chk("sat_rdy1", 32'(req_ready), 32'h38);
        @(negedge clk);
        chk("sat_cmplt1", 32'(completed), 32'(slots(5'd4, 5'd5, 5'd6)));
        chk("sat_vld1", 32'(cmplt_valid), 32'h7);
        chk("sat_rdy2", 32'(req_ready), 32'h07);
        @(negedge clk);
        chk("sat_cmplt2", 32'(completed), 32'(slots(5'd1, 5'd2, 5'd3)));
        chk("sat_vld2", 32'(cmplt_valid), 32'h7);
        chk("sat_ptr", 32'(dut.rr_ptr), 3);
        req_valid = '0;
        @(negedge clk);
        chk("nohold_vld", 32'(cmplt_valid), 0);
        chk("nohold_ct", 32'(grant_ct), 0);

        // Move pointer to 4, then wrap-around
        req_valid = 6'b001000;
        set_tag(3, 5'd7);
        @(negedge clk);
        chk("single_cmplt", 32'(completed), 32'(slots(5'd7, 5'd0, 5'd0)));
        chk("single_ct", 32'(grant_ct), 1);
        chk("wrap_ptr0", 32'(dut.rr_ptr), 4);
        req_valid = 6'b110011;
        set_tag(0, 5'd10);
        set_tag(1, 5'd11);
        set_tag(4, 5'd14);
        set_tag(5, 5'd15);
        #1;
        chk("wrap_rdy", 32'(req_ready), 32'h31);
        @(negedge clk);
        chk("wrap_cmplt", 32'(completed), 32'(slots(5'd14, 5'd15, 5'd10)));
        chk("wrap_vld", 32'(cmplt_valid), 32'h7);
        chk("wrap_ptr1", 32'(dut.rr_ptr), 1);
        req_valid = 6'b000010;
        #1;
        chk("wrap_rdy1", 32'(req_ready), 32'h02);
        @(negedge clk);
        chk("wrap_cmplt1", 32'(completed), 32'(slots(5'd11, 5'd0, 5'd0)));
        chk("wrap_vld1", 32'(cmplt_valid), 32'h1);
        chk("wrap_ct1", 32'(grant_ct), 1);
        chk("wrap_ptr2", 32'(dut.rr_ptr), 2);

        // Flush wins over requests
        req_valid = 6'b000111;
        set_tag(0, 5'd20);
        set_tag(1, 5'd21);
        set_tag(2, 5'd22);
        flush = 1'b1;
        #1;
        chk("flush_rdy", 32'(req_ready), 0);
        @(negedge clk);
        chk("flush_vld", 32'(cmplt_valid), 0);
        chk("flush_cmplt", 32'(completed), 0);
        chk("flush_ct", 32'(grant_ct), 0);
        chk("flush_ptr", 32'(dut.rr_ptr), 2);
        flush = 1'b0;
        #1;
        chk("postflush_rdy", 32'(req_ready), 32'h07);
        @(negedge clk);
        chk("postflush_cmplt", 32'(completed), 32'(slots(5'd22, 5'd20, 5'd21)));
        chk("postflush_vld", 32'(cmplt_valid), 32'h7);
        chk("postflush_ptr", 32'(dut.rr_ptr), 2);
        req_valid = '0;

        // Held random requests against a reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        pend  = '0;
        exp_c = '0;
        exp_v = '0;
        exp_n = '0;
        for (int i = 0; i < 6; i++) begin
            ptag[i]   = '0;
            wait_c[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            chk("rnd_cmplt", 32'(completed), 32'(exp_c));
            chk("rnd_vld", 32'(cmplt_valid), 32'(exp_v));
            chk("rnd_ct", 32'(grant_ct), 32'(exp_n));
            for (int u = 0; u < 6; u++) begin
                if (!pend[u] && ($urandom_range(0, 1) == 1)) begin
                    pend[u]   = 1'b1;
                    ptag[u]   = 5'($urandom_range(0, 31));
                    wait_c[u] = 0;
                end
                set_tag(u, ptag[u]);
            end
            req_valid = pend;
            #1;
            exp_rdy = '0;
            exp_c   = '0;
            exp_v   = '0;
            g       = 0;
            last    = -1;
            for (int i = 0; i < 6; i++) begin
                r = (mptr + i) % 6;
                if (pend[r] && g < 3) begin
                    exp_rdy[r]       = 1'b1;
                    exp_c[g*5 +: 5]  = ptag[r];
                    exp_v[g]         = 1'b1;
                    g++;
                    last = r;
                end
            end
            exp_n = 2'(g);
            chk("rnd_rdy", 32'(req_ready), 32'(exp_rdy));
            for (int u = 0; u < 6; u++) begin
                if (pend[u]) begin
                    wait_c[u]++;
                    if (exp_rdy[u]) begin
                        chk("rnd_wait_le2", 32'(wait_c[u] <= 2), 1);
                        pend[u] = 1'b0;
                    end
                end
            end
            if (g > 0) mptr = (last + 1) % 6;
        end
        @(negedge clk);
        chk("rnd_cmplt_last", 32'(completed), 32'(exp_c));
        chk("rnd_vld_last", 32'(cmplt_valid), 32'(exp_v));
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
